// File: rtl/quadrature_debounce.sv
// Quadrature encoder input conditioner.
// Synchronises raw A/B, then filters them jointly as one 2-bit code so that
// contact bounce on either channel never reaches the downstream decoder.
// Accepted code changes produce a one-cycle step pulse. Two-bit jumps also
// produce an illegal pulse. Abandoned candidate codes are counted in a
// saturating glitch counter.
module quadrature_debounce #(
    parameter int STABLE_CYCLES = 50,
    parameter int CNT_W         = 6,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                A_in,
    input  logic                B_in,
    output logic                A,
    output logic                B,
    output logic                step,
    output logic                illegal,
    output logic [GLITCH_W-1:0] glitch_count
);

    // Last count value before a pending code is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [1:0]          sync1_q, sync1_d;
    logic [1:0]          sync2_q, sync2_d;
    logic [1:0]          cand_q, cand_d;
    logic [1:0]          out_q, out_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                step_q, step_d;
    logic                illegal_q, illegal_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic                pending;

    // Two-flop synchroniser: a plain shift with nothing between the stages.
    always_comb begin
        sync1_d = {A_in, B_in};
        sync2_d = sync1_q;
    end

    // Joint filter: a new code restarts the timer; a code that survives
    // STABLE_CYCLES+1 samples is forwarded. Leaving a pending code is a glitch.
    always_comb begin
        pending   = (cand_q != out_q);
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        step_d    = 1'b0;
        illegal_d = 1'b0;
        glitch_d  = glitch_q;

        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
            if (pending && (glitch_q != '1)) begin
                glitch_d = glitch_q + 1'b1;
            end
        end else if (pending && (cnt_q == CNT_LAST)) begin
            out_d     = cand_q;
            cnt_d     = '0;
            step_d    = 1'b1;
            // Both bits flipping at once is forwarded but flagged.
            illegal_d = ((out_q ^ cand_q) == 2'b11);
        end else if (pending) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end
    end

    // State registers; reset discards any pending transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 2'b00;
            sync2_q   <= 2'b00;
            cand_q    <= 2'b00;
            out_q     <= 2'b00;
            cnt_q     <= '0;
            step_q    <= 1'b0;
            illegal_q <= 1'b0;
            glitch_q  <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cand_q    <= cand_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            illegal_q <= illegal_d;
            glitch_q  <= glitch_d;
        end
    end

    assign A            = out_q[1];
    assign B            = out_q[0];
    assign step         = step_q;
    assign illegal      = illegal_q;
    assign glitch_count = glitch_q;

endmodule

// File: tb/tb_quadrature_debounce.sv
// Testbench for quadrature_debounce: directed scenarios followed by random
// bouncing input, all checked each cycle against a run-length reference model.
module tb_quadrature_debounce;

    localparam int S    = 4;
    localparam int GW   = 2;
    localparam int GMAX = (1 << GW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          A_in = 1'b0;
    logic          B_in = 1'b0;
    logic          A;
    logic          B;
    logic          step;
    logic          illegal;
    logic [GW-1:0] glitch_count;

    int n_cmp = 0;
    int n_bad = 0;
    int step_seen = 0;

    // Reference model: raw-sample history plus the current run of identical
    // filtered-input samples. A run of a new code lasting S+1 samples is
    // accepted; a run of a not-yet-accepted code that ends is a glitch.
    logic [1:0] hist1_m, hist2_m;
    logic [1:0] run_val_m, out_m;
    int         run_len_m;
    logic       step_m, illegal_m;
    int         glitch_m;

    quadrature_debounce #(
        .STABLE_CYCLES(S),
        .CNT_W(6),
        .GLITCH_W(GW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .A_in(A_in),
        .B_in(B_in),
        .A(A),
        .B(B),
        .step(step),
        .illegal(illegal),
        .glitch_count(glitch_count)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [1:0] raw);
        logic [1:0] s;
        if (r) begin
            hist1_m   = 2'b00;
            hist2_m   = 2'b00;
            run_val_m = 2'b00;
            run_len_m = 0;
            out_m     = 2'b00;
            step_m    = 1'b0;
            illegal_m = 1'b0;
            glitch_m  = 0;
        end else begin
            s         = hist2_m;
            hist2_m   = hist1_m;
            hist1_m   = raw;
            step_m    = 1'b0;
            illegal_m = 1'b0;
            if (s == run_val_m) begin
                run_len_m++;
            end else begin
                if (run_val_m != out_m && glitch_m < GMAX) glitch_m++;
                run_val_m = s;
                run_len_m = 1;
            end
            if (run_val_m != out_m && run_len_m == S + 1) begin
                illegal_m = ((run_val_m ^ out_m) == 2'b11);
                out_m     = run_val_m;
                step_m    = 1'b1;
            end
        end
    endtask

    // One clock: drive at negedge, update model at posedge, compare 1 ns later.
    task automatic tick(input logic a, input logic b, input logic r);
        @(negedge clk);
        A_in  = a;
        B_in  = b;
        reset = r;
        @(posedge clk);
        model_edge(r, {a, b});
        #1;
        chk("A", 32'(A), 32'(out_m[1]));
        chk("B", 32'(B), 32'(out_m[0]));
        chk("step", 32'(step), 32'(step_m));
        chk("illegal", 32'(illegal), 32'(illegal_m));
        chk("glitch_count", 32'(glitch_count), 32'(glitch_m));
        if (step === 1'b1) step_seen++;
        $display("t=%0t rst=%b in=%b%b | AB=%b%b step=%b ill=%b gc=%0d | exp AB=%b step=%b ill=%b gc=%0d",
                 $time, r, a, b, A, B, step, illegal, glitch_count,
                 out_m, step_m, illegal_m, glitch_m);
    endtask

    task automatic hold(input logic [1:0] code, input int n);
        for (int i = 0; i < n; i++) tick(code[1], code[0], 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1);
    endtask

    int exp6[6];

    initial begin
        exp6 = '{1, 2, 3, 3, 3, 3};

        // 1. Reset held with inputs at 11, then release.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1);
        chk("t1_rst_ab", 32'({A, B}), 32'd0);
        chk("t1_rst_gc", 32'(glitch_count), 32'd0);
        step_seen = 0;
        hold(2'b11, 6);
        chk("t1_pre_ab", 32'({A, B}), 32'd0);
        hold(2'b11, 1);
        chk("t1_ab", 32'({A, B}), 32'd3);
        chk("t1_step", 32'(step), 32'd1);
        chk("t1_illegal", 32'(illegal), 32'd1);
        hold(2'b11, 4);
        chk("t1_steps", 32'(step_seen), 32'd1);

        // 2. Clockwise sequence, each code held 10 cycles.
        do_reset(2);
        hold(2'b00, 3);
        step_seen = 0;
        hold(2'b10, 10);
        hold(2'b11, 10);
        hold(2'b01, 10);
        hold(2'b00, 10);
        hold(2'b00, 8);
        chk("t2_steps", 32'(step_seen), 32'd4);
        chk("t2_gc", 32'(glitch_count), 32'd0);
        chk("t2_ab", 32'({A, B}), 32'd0);

        // 3. Two-cycle glitch on A.
        do_reset(2);
        hold(2'b00, 3);
        step_seen = 0;
        hold(2'b10, 2);
        hold(2'b00, 12);
        chk("t3_gc", 32'(glitch_count), 32'd1);
        chk("t3_steps", 32'(step_seen), 32'd0);
        chk("t3_a", 32'(A), 32'd0);

        // 4. Bounce 1,0,1 then settle high.
        do_reset(2);
        hold(2'b00, 3);
        step_seen = 0;
        hold(2'b10, 1);
        hold(2'b00, 1);
        hold(2'b10, 6);
        chk("t4_pre_a", 32'(A), 32'd0);
        hold(2'b10, 1);
        chk("t4_a_rise", 32'(A), 32'd1);
        hold(2'b10, 6);
        chk("t4_gc", 32'(glitch_count), 32'd1);
        chk("t4_steps", 32'(step_seen), 32'd1);

        // 5. Reset pulse on the 4th cycle of a pending rise.
        do_reset(2);
        hold(2'b00, 3);
        hold(2'b10, 3);
        tick(1'b1, 1'b0, 1'b1);
        chk("t5_rst_a", 32'(A), 32'd0);
        hold(2'b10, 6);
        chk("t5_pre_a", 32'(A), 32'd0);
        hold(2'b10, 1);
        chk("t5_a_rise", 32'(A), 32'd1);

        // 6. Glitch counter saturation.
        do_reset(2);
        hold(2'b00, 3);
        step_seen = 0;
        for (int k = 0; k < 6; k++) begin
            hold(2'b10, 2);
            hold(2'b00, 8);
            chk("t6_gc", 32'(glitch_count), 32'(exp6[k]));
        end
        chk("t6_steps", 32'(step_seen), 32'd0);
        chk("t6_ab", 32'({A, B}), 32'd0);

        // 7. Random bouncing codes with occasional reset.
        do_reset(2);
        for (int k = 0; k < 80; k++) begin
            logic [1:0] code;
            int len;
            code = 2'($urandom_range(0, 3));
            len  = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                tick(code[1], code[0], ($urandom_range(0, 99) == 0));
            end
        end
        hold(2'b00, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/quadrature_debounce.md
Name: quadrature_debounce

Overview:
Input conditioner for the wheel's quadrature encoder channels. It sits directly upstream of the wheel decoder (count/CW/CWW logic) and feeds it clean A/B levels. Raw A/B from the GPIO pins are synchronised, then filtered jointly as a 2-bit code so contact bounce never reaches the decoder. A/B updates arrive with a step pulse; simultaneous two-bit changes are flagged, and aborted transitions are counted for diagnostics.

Parameters:
STABLE_CYCLES, 50, clock cycles a new AB code must persist before acceptance (1 us at 50 MHz); legal range 1..2^CNT_W-1
CNT_W, 6, width of the stability counter
GLITCH_W, 8, width of the saturating glitch counter

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high reset
A_in  input  1  raw encoder channel A, asynchronous to clk
B_in  input  1  raw encoder channel B, asynchronous to clk
A  output  1  filtered channel A, drives decoder A
B  output  1  filtered channel B, drives decoder B
step  output  1  one-cycle pulse when {A,B} changes
illegal  output  1  one-cycle pulse when A and B change on the same update
glitch_count  output  GLITCH_W  number of aborted pending transitions, saturating

Behaviour:
- One clock; reset is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset: sync1, sync2, cand and out = 2'b00; cnt = 0; A = B = 0; step = illegal = 0; glitch_count = 0. Reset overrides every other action and discards any pending transition.
- Synchroniser: sync1 <= {A_in,B_in}; sync2 <= sync1. No logic is placed between the two flops.
- Filter registers: cand (2b), cnt (CNT_W), out (2b); A = out[1], B = out[0]. "Pending" means cand != out.
- Per cycle, in priority order:
  1. If sync2 != cand: cand <= sync2, cnt <= 0. If pending, also glitch_count <= glitch_count+1, saturating at all-ones. A return to the old out value while pending also counts as a glitch.
  2. Else if pending and cnt == STABLE_CYCLES-1: out <= cand, cnt <= 0, step <= 1. Also illegal <= 1 if (out ^ cand) == 2'b11.
  3. Else if pending: cnt <= cnt+1.
  4. Else: cnt <= 0.
- step and illegal are registered. Each is high only in the cycle after the edge on which out updates, and is 0 in all other cycles.
- Latency: a raw change sampled into sync1 on edge 1 reaches A/B on edge STABLE_CYCLES+3, provided the input is held.
  - Minimum accepted pulse width: STABLE_CYCLES+1 cycles.
  - Narrower pulses never reach A/B.
- Illegal codes are still forwarded to out. The downstream decoder decides what to do with them.
- glitch_count does not wrap. It holds at 2^GLITCH_W-1 until reset.
- Both channels are filtered as one code. A bounce on either channel restarts the timer for both.

Test Plan:
- Bench settings: STABLE_CYCLES=4, 20 ns clock, inputs changed at negedge.
1. Reset release: hold reset with A_in=B_in=1, then release -> A=B=0, step=0, glitch_count=0 while in reset. AB becomes 11 on the 7th edge after the first post-reset sampling edge, with step=1 and illegal=1 for one cycle.
2. CW sequence 00->10->11->01->00, each code held 10 cycles -> A/B reproduce the sequence delayed 7 edges, exactly 4 step pulses, illegal=0, glitch_count=0.
3. Short glitch: A_in=1 for 2 cycles, then 0, with B_in=0 throughout -> A stays 0, no step, glitch_count=1.
4. Bounce then settle: A_in = 1,0,1 (one cycle each), then held at 1 -> glitch_count=1. A rises exactly once, 7 edges after the final 0->1 sampling edge, with a single step pulse.
5. Reset mid-pending: A_in rises, reset pulsed for 1 cycle on the 4th cycle, A_in stays 1 -> A=0 through reset. A rises on the 7th edge after the first post-reset sampling edge, since the synchroniser was cleared.
6. Saturation with GLITCH_W=2: six 2-cycle A_in pulses spaced 10 cycles apart -> glitch_count reads 1,2,3,3,3,3. A and B stay 0 and step never asserts.
